// File: rtl/miss_arbiter_pkg.sv
// miss_arb_pkg
//   Shared constants and types for the memblk read-miss arbiter slice.
//   NREQ cores share one miss port. Each miss carries an AW-bit address and
//   comes back as a PW-bit physical line. At most DEPTH misses are
//   outstanding at any time, and each is tagged with an IDW-bit requester ID.
package miss_arb_pkg;

  localparam int NREQ  = 36;
  localparam int AW    = 39;
  localparam int PW    = 40;
  localparam int DEPTH = 8;
  localparam int IDW   = 6;

  // Pointer and occupancy width. The extra MSB tells full apart from empty.
  localparam int OCCW  = $clog2(DEPTH) + 1;

  typedef logic [IDW-1:0] req_id_t;

  typedef struct packed {
    logic [AW-1:0] addr;
    req_id_t       id;
  } miss_req_t;

endpackage

// File: rtl/miss_arbiter_if.sv
// miss_arbiter_if
//   Bundles the core-side miss signals and the memblk-side issue/response
//   signals of the miss arbiter.
//   Core side   : req_en, req_addr -> arbiter; req_busy, rsp_done, rsp_phy <- arbiter
//   memblk side : mem_stall, mem_rvalid, mem_rphy -> arbiter;
//                 mem_rden, mem_addr, mem_id <- arbiter
//   Modport slave is the arbiter's view. Modport master is the view of the
//   cores and memblk that drive it.
interface miss_arbiter_if;
  import miss_arb_pkg::*;

  logic [NREQ-1:0]         req_en;
  logic [NREQ-1:0][AW-1:0] req_addr;
  logic [NREQ-1:0]         req_busy;

  logic                    mem_stall;
  logic                    mem_rden;
  logic [AW-1:0]           mem_addr;
  req_id_t                 mem_id;
  logic                    mem_rvalid;
  logic [PW-1:0]           mem_rphy;

  logic [NREQ-1:0]         rsp_done;
  logic [PW-1:0]           rsp_phy;

  modport slave (
    input  req_en, req_addr, mem_stall, mem_rvalid, mem_rphy,
    output req_busy, mem_rden, mem_addr, mem_id, rsp_done, rsp_phy
  );

  modport master (
    output req_en, req_addr, mem_stall, mem_rvalid, mem_rphy,
    input  req_busy, mem_rden, mem_addr, mem_id, rsp_done, rsp_phy
  );

endinterface

// File: rtl/miss_arbiter_id_fifo.sv
// miss_id_fifo
//   In-order FIFO of requester IDs, DEPTH entries of IDW bits, for misses
//   that have been issued to memblk and not yet answered.
//   Ports:
//     clk, rst   clock and synchronous active-high reset (empties the FIFO)
//     push       write push_id at the tail
//     pop        drop the head entry
//     head_id    current head entry, valid while empty is low
//     empty      no outstanding entries
//     occupancy  number of stored entries, 0..DEPTH
//   A push and a pop in the same cycle are allowed even when the FIFO is full.
module miss_id_fifo
  import miss_arb_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  req_id_t         push_id,
  input  logic            pop,
  output req_id_t         head_id,
  output logic            empty,
  output logic [OCCW-1:0] occupancy
);

  localparam int LW = $clog2(DEPTH);

  req_id_t         mem [DEPTH];
  logic [OCCW-1:0] wr_ptr;
  logic [OCCW-1:0] rd_ptr;
  logic            full;
  logic            do_push;
  logic            do_pop;

  // Both pointers carry one extra wrap bit. The FIFO is full when the wrap
  // bits differ and the index bits match.
  assign full      = (wr_ptr[LW] != rd_ptr[LW]) && (wr_ptr[LW-1:0] == rd_ptr[LW-1:0]);
  assign empty     = (wr_ptr == rd_ptr);
  assign occupancy = wr_ptr - rd_ptr;
  assign head_id   = mem[rd_ptr[LW-1:0]];

  // A push into a full FIFO is accepted only when the head leaves in the
  // same cycle. The write then reuses the slot being vacated.
  assign do_push = push & (~full | do_pop);
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: the pointers decide which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[LW-1:0]] <= push_id;
  end

endmodule

// File: rtl/miss_arbiter.sv
// miss_arbiter
//   Shares the single memblk read-miss port among NREQ cores. Each core's
//   miss is latched, one latched miss is issued per cycle in round-robin
//   order, the IDs of in-flight misses are tracked in order, and each
//   returned physical line is sent back to the core that asked for it.
//   Ports:
//     clk, rst     clock and synchronous active-high reset
//     bus          miss_arbiter_if.slave: core requests/busy/completions and
//                  memblk issue/stall/response
//     err_orphan   sticky flag: a response arrived with nothing outstanding
//   Optional (macro MISS_ARB_STATS_EN):
//     stat_issue   count of issue cycles (mem_rden high), wraps at 2^32
//     stat_stall   count of cycles with a pending miss that could not issue
//     stat_maxocc  peak number of outstanding misses
module miss_arbiter
  import miss_arb_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  miss_arbiter_if.slave   bus,
  output logic            err_orphan
`ifdef MISS_ARB_STATS_EN
  ,
  output logic [31:0]     stat_issue,
  output logic [31:0]     stat_stall,
  output logic [OCCW-1:0] stat_maxocc
`endif
);

  logic [NREQ-1:0] pend;
  logic [NREQ-1:0] busy;
  logic [AW-1:0]   addr_q [NREQ];
  req_id_t         rr_ptr;

  logic            rden_q;
  miss_req_t       issue_q;
  logic [NREQ-1:0] done_q;
  logic [PW-1:0]   phy_q;
  logic            orphan_q;

  logic [NREQ-1:0] capture;
  logic            pop;
  logic            eligible;
  req_id_t         winner;
  logic [NREQ-1:0] issue_mask;
  logic [NREQ-1:0] done_mask;

  req_id_t         fifo_head;
  logic            fifo_empty;
  logic [OCCW-1:0] fifo_occ;

  // Rotating-priority pick: the first pending core at or after ptr, wrapping
  // around to core 0. Returns 0 when nothing is pending, and the caller gates
  // the result on |req.
  function automatic req_id_t rr_pick(input logic [NREQ-1:0] req, input req_id_t ptr);
    req_id_t win;
    logic    found;
    int      idx;
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = IDW'(idx);
      end
    end
    return win;
  endfunction

  miss_id_fifo u_id_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (eligible),
    .push_id   (winner),
    .pop       (pop),
    .head_id   (fifo_head),
    .empty     (fifo_empty),
    .occupancy (fifo_occ)
  );

  // A core is captured only while it is idle, so a core can never be
  // captured and issued in the same cycle. A slot freed by a pop this cycle
  // can take this cycle's issue.
  always_comb begin
    capture    = bus.req_en & ~busy;
    pop        = bus.mem_rvalid & ~fifo_empty;
    eligible   = ~bus.mem_stall & (|pend) & ((fifo_occ < OCCW'(DEPTH)) | pop);
    winner     = rr_pick(pend, rr_ptr);
    issue_mask = '0;
    done_mask  = '0;
    if (eligible) issue_mask = NREQ'(1) << winner;
    if (pop)      done_mask  = NREQ'(1) << fifo_head;
  end

  // Control state and registered outputs. busy stays set from capture until
  // the response lands, which covers both the latched and in-flight phases.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend     <= '0;
      busy     <= '0;
      rr_ptr   <= '0;
      rden_q   <= 1'b0;
      issue_q  <= '0;
      done_q   <= '0;
      phy_q    <= '0;
      orphan_q <= 1'b0;
    end else begin
      pend   <= (pend & ~issue_mask) | capture;
      busy   <= (busy & ~done_mask) | capture;
      rden_q <= eligible;
      done_q <= done_mask;
      if (eligible) begin
        issue_q.addr <= addr_q[winner];
        issue_q.id   <= winner;
        rr_ptr       <= (winner == IDW'(NREQ - 1)) ? '0 : winner + 1'b1;
      end
      if (pop) phy_q <= bus.mem_rphy;
      if (bus.mem_rvalid && fifo_empty) orphan_q <= 1'b1;
    end
  end

  // The address latch needs no reset. It is read only while the matching
  // pend bit is set.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (capture[i]) addr_q[i] <= bus.req_addr[i];
    end
  end

  assign bus.req_busy = busy;
  assign bus.mem_rden = rden_q;
  assign bus.mem_addr = issue_q.addr;
  assign bus.mem_id   = issue_q.id;
  assign bus.rsp_done = done_q;
  assign bus.rsp_phy  = phy_q;
  assign err_orphan   = orphan_q;

`ifdef MISS_ARB_STATS_EN
  // Statistics counters. stat_maxocc cannot exceed DEPTH because occupancy
  // never does.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_issue  <= '0;
      stat_stall  <= '0;
      stat_maxocc <= '0;
    end else begin
      if (rden_q)               stat_issue  <= stat_issue + 1'b1;
      if ((|pend) && !eligible) stat_stall  <= stat_stall + 1'b1;
      if (fifo_occ > stat_maxocc) stat_maxocc <= fifo_occ;
    end
  end
`endif

endmodule

// File: tb/tb_miss_arbiter.sv
// tb_miss_arbiter
//   Directed-vector bench for miss_arbiter. Each sequence drives the bus
//   interface and compares the registered outputs with hand-computed values.
module tb_miss_arbiter;
  import miss_arb_pkg::*;

  logic clk;
  logic rst;
  logic err_orphan;
`ifdef MISS_ARB_STATS_EN
  logic [31:0]     stat_issue;
  logic [31:0]     stat_stall;
  logic [OCCW-1:0] stat_maxocc;
`endif

  int testCount = 0;
  int failCount = 0;

  miss_arbiter_if bus();

  miss_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .err_orphan (err_orphan)
`ifdef MISS_ARB_STATS_EN
    ,
    .stat_issue (stat_issue),
    .stat_stall (stat_stall),
    .stat_maxocc(stat_maxocc)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock. Inputs change and outputs are sampled 1 ns after the edge.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  initial begin
    rst            = 1'b1;
    bus.req_en     = '0;
    bus.req_addr   = '0;
    bus.mem_stall  = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rphy   = '0;
    applyStimulus();
    applyStimulus();
    rst = 1'b0;

    // Reset state
    checkOutput("rst_rden",   64'(bus.mem_rden), 64'd0);
    checkOutput("rst_addr",   64'(bus.mem_addr), 64'd0);
    checkOutput("rst_id",     64'(bus.mem_id),   64'd0);
    checkOutput("rst_done",   64'(bus.rsp_done), 64'd0);
    checkOutput("rst_phy",    64'(bus.rsp_phy),  64'd0);
    checkOutput("rst_busy",   64'(bus.req_busy), 64'd0);
    checkOutput("rst_orphan", 64'(err_orphan),   64'd0);

    // Fairness: all cores request at once and are issued 0..35 back to back.
    // Responses are returned every cycle so the ID FIFO never fills.
    for (int i = 0; i < NREQ; i++) bus.req_addr[i] = AW'(32'h1000 + i);
    bus.req_en = '1;
    applyStimulus();
    bus.req_en = '0;
    checkOutput("fair_busy", 64'(bus.req_busy), 64'hF_FFFF_FFFF);
    checkOutput("fair_rden0", 64'(bus.mem_rden), 64'd0);
    applyStimulus();
    for (int k = 0; k < NREQ; k++) begin
      checkOutput("fair_rden", 64'(bus.mem_rden), 64'd1);
      checkOutput("fair_id",   64'(bus.mem_id),   64'(k));
      checkOutput("fair_addr", 64'(bus.mem_addr), 64'h1000 + 64'(k));
      if (k > 0) checkOutput("fair_done", 64'(bus.rsp_done), 64'd1 << (k - 1));
      bus.mem_rvalid = 1'b1;
      bus.mem_rphy   = PW'(32'hF00 + k);
      applyStimulus();
    end
    bus.mem_rvalid = 1'b0;
    checkOutput("fair_done_last", 64'(bus.rsp_done), 64'd1 << 35);
    checkOutput("fair_phy_last",  64'(bus.rsp_phy),  64'hF23);
    checkOutput("fair_rden_end",  64'(bus.mem_rden), 64'd0);
    checkOutput("fair_busy_end",  64'(bus.req_busy), 64'd0);

    // Credit limit: 12 requests with no responses. Exactly 8 issue, in order
    // 0..7, which also shows rr_ptr wrapped back to 0.
    for (int i = 0; i < 12; i++) bus.req_addr[i] = AW'(32'h200 + i);
    bus.req_en = 36'hFFF;
    applyStimulus();
    bus.req_en = '0;
    applyStimulus();
    for (int k = 0; k < DEPTH; k++) begin
      checkOutput("cred_rden", 64'(bus.mem_rden), 64'd1);
      checkOutput("cred_id",   64'(bus.mem_id),   64'(k));
      applyStimulus();
    end
    checkOutput("cred_full_a", 64'(bus.mem_rden), 64'd0);
    applyStimulus();
    checkOutput("cred_full_b", 64'(bus.mem_rden), 64'd0);
    // One response frees a slot, and the next miss issues in the same cycle.
    bus.mem_rvalid = 1'b1;
    bus.mem_rphy   = PW'(32'h55);
    applyStimulus();
    bus.mem_rvalid = 1'b0;
    checkOutput("cred_pp_rden", 64'(bus.mem_rden), 64'd1);
    checkOutput("cred_pp_id",   64'(bus.mem_id),   64'd8);
    checkOutput("cred_pp_done", 64'(bus.rsp_done), 64'd1);
    checkOutput("cred_pp_phy",  64'(bus.rsp_phy),  64'h55);
    applyStimulus();
    checkOutput("cred_full_c", 64'(bus.mem_rden), 64'd0);
    // Drain: responses come back in issue order 1..11.
    for (int k = 1; k < 12; k++) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_rphy   = PW'(k);
      applyStimulus();
      checkOutput("cred_drain_done", 64'(bus.rsp_done), 64'd1 << k);
    end
    bus.mem_rvalid = 1'b0;
    applyStimulus();
    checkOutput("cred_busy_end", 64'(bus.req_busy), 64'd0);
    checkOutput("cred_orphan",   64'(err_orphan),   64'd0);

    // Single request: req_en at t gives mem_rden at t+2.
    bus.req_addr[5] = AW'(32'h123);
    bus.req_en[5]   = 1'b1;
    applyStimulus();
    bus.req_en = '0;
    checkOutput("single_rden_t1", 64'(bus.mem_rden), 64'd0);
    checkOutput("single_busy",    64'(bus.req_busy), 64'd1 << 5);
    applyStimulus();
    checkOutput("single_rden", 64'(bus.mem_rden), 64'd1);
    checkOutput("single_addr", 64'(bus.mem_addr), 64'h123);
    checkOutput("single_id",   64'(bus.mem_id),   64'd5);
    bus.mem_rvalid = 1'b1;
    bus.mem_rphy   = PW'(32'hAB);
    applyStimulus();
    bus.mem_rvalid = 1'b0;
    checkOutput("single_done", 64'(bus.rsp_done), 64'd1 << 5);
    checkOutput("single_phy",  64'(bus.rsp_phy),  64'hAB);
    checkOutput("single_free", 64'(bus.req_busy), 64'd0);
    // The core re-requests in the cycle its completion lands.
    bus.req_addr[5] = AW'(32'h124);
    bus.req_en[5]   = 1'b1;
    applyStimulus();
    bus.req_en = '0;
    checkOutput("recap_busy", 64'(bus.req_busy), 64'd1 << 5);
    checkOutput("recap_done_clr", 64'(bus.rsp_done), 64'd0);
    applyStimulus();
    checkOutput("recap_rden", 64'(bus.mem_rden), 64'd1);
    checkOutput("recap_addr", 64'(bus.mem_addr), 64'h124);
    bus.mem_rvalid = 1'b1;
    applyStimulus();
    bus.mem_rvalid = 1'b0;
    checkOutput("recap_done", 64'(bus.rsp_done), 64'd1 << 5);

    // Stall: pend[3] is held off for 5 cycles and issues one cycle after
    // the stall drops.
    bus.mem_stall   = 1'b1;
    bus.req_addr[3] = AW'(32'h333);
    bus.req_en[3]   = 1'b1;
    applyStimulus();
    bus.req_en = '0;
    for (int k = 0; k < 5; k++) begin
      checkOutput("stall_rden", 64'(bus.mem_rden), 64'd0);
      applyStimulus();
    end
    bus.mem_stall = 1'b0;
    applyStimulus();
    checkOutput("stall_rel_rden", 64'(bus.mem_rden), 64'd1);
    checkOutput("stall_rel_id",   64'(bus.mem_id),   64'd3);
    checkOutput("stall_rel_addr", 64'(bus.mem_addr), 64'h333);
    bus.mem_rvalid = 1'b1;
    applyStimulus();
    bus.mem_rvalid = 1'b0;
    checkOutput("stall_done", 64'(bus.rsp_done), 64'd1 << 3);

    // Busy drop: a second req_en[7] while busy is ignored.
    bus.req_addr[7] = AW'(32'h700);
    bus.req_en[7]   = 1'b1;
    applyStimulus();
    bus.req_addr[7] = AW'(32'h7FF);
    applyStimulus();
    checkOutput("drop_id",   64'(bus.mem_id),   64'd7);
    checkOutput("drop_addr", 64'(bus.mem_addr), 64'h700);
    applyStimulus();
    bus.req_en = '0;
    checkOutput("drop_rden", 64'(bus.mem_rden), 64'd0);
    bus.mem_rvalid = 1'b1;
    applyStimulus();
    bus.mem_rvalid = 1'b0;
    checkOutput("drop_done", 64'(bus.rsp_done), 64'd1 << 7);
    applyStimulus();
    checkOutput("drop_no_reissue", 64'(bus.mem_rden), 64'd0);

    // Orphan: a response with nothing outstanding.
    bus.mem_rvalid = 1'b1;
    bus.mem_rphy   = PW'(32'hEE);
    applyStimulus();
    bus.mem_rvalid = 1'b0;
    checkOutput("orphan_set",  64'(err_orphan),   64'd1);
    checkOutput("orphan_done", 64'(bus.rsp_done), 64'd0);
    applyStimulus();
    checkOutput("orphan_sticky", 64'(err_orphan), 64'd1);

    // Reset with 4 misses outstanding discards everything.
    bus.req_en = 36'h0_0000_3C00;
    applyStimulus();
    bus.req_en = '0;
    for (int k = 10; k < 14; k++) begin
      applyStimulus();
      checkOutput("mid_id", 64'(bus.mem_id), 64'(k));
    end
    rst = 1'b1;
    applyStimulus();
    rst = 1'b0;
    checkOutput("mid_busy",   64'(bus.req_busy), 64'd0);
    checkOutput("mid_orphan", 64'(err_orphan),   64'd0);
    checkOutput("mid_rden",   64'(bus.mem_rden), 64'd0);
    // With an empty FIFO, a late response is an orphan and completes nothing.
    bus.mem_rvalid = 1'b1;
    applyStimulus();
    bus.mem_rvalid = 1'b0;
    checkOutput("mid_late_orphan", 64'(err_orphan),   64'd1);
    checkOutput("mid_late_done",   64'(bus.rsp_done), 64'd0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
